// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer running one aligned word-bus transaction per accepted access.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   access handshake from execute; ready only while idle
//   mem_access_type   3'b0ss: load, 3'b1ss: store; ss = 01 byte, 10 half, 11 word, 00 none
//   mem_sign_ext      sign-extend byte/half loads
//   addr, wdata       effective byte address and store source
//   stall             holds the pipeline while busy or while a valid access is presented
//   done/misalign/bus_err  mutually exclusive one-cycle status pulses
//   ld_data           extended load result, held until the next load completes
//   bus_*             registered word-bus request, write strobes/data, grant and read response
module lsu_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            mem_access_type,
  input  logic                  mem_sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t          r_state;
  logic [1:0]      r_size;
  logic            r_sext;
  logic [1:0]      r_off;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      w_size;
  logic            w_none;
  logic            w_mis;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_to;
  logic [3:0]      w_wstrb;
  logic [31:0]     w_wdata;
  logic [31:0]     w_lane;
  logic [31:0]     w_ld;
  assign w_size    = mem_access_type[1:0];
  assign w_none    = w_size == 2'b00;
  assign w_mis     = (w_size == 2'b10 && addr[0]) || (w_size == 2'b11 && addr[1:0] != 2'b00);
  assign req_ready = r_state == IDLE;
  assign stall     = (r_state != IDLE) || (req_valid && !w_none && !w_mis);
  assign w_cnt_nxt = r_cnt + 1'b1;
  // Abort once the count of waiting cycles reaches the limit; a limit of 0 never aborts.
  assign w_to      = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CW'(TIMEOUT_CYCLES));
  assign w_wstrb   = !mem_access_type[2] ? 4'b0000 :
                     w_size == 2'b01 ? 4'b0001 << addr[1:0] :
                     w_size == 2'b10 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  assign w_wdata   = w_size == 2'b01 ? {4{wdata[7:0]}} :
                     w_size == 2'b10 ? {2{wdata[15:0]}} : wdata;
  // Bring the addressed byte/half down to bit 0 before extension.
  assign w_lane    = bus_rdata >> (r_size == 2'b01 ? {r_off, 3'b000} : {r_off[1], 4'b0000});
  assign w_ld      = r_size == 2'b01 ? {{24{r_sext & w_lane[7]}}, w_lane[7:0]} :
                     r_size == 2'b10 ? {{16{r_sext & w_lane[15]}}, w_lane[15:0]} : bus_rdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_size    <= 2'b00;
      r_sext    <= 1'b0;
      r_off     <= 2'b00;
      r_cnt     <= '0;
      done      <= 1'b0;
      ld_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= 4'b0000;
      bus_wdata <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        IDLE: if (req_valid && !w_none) begin
          if (w_mis) misalign <= 1'b1;
          else begin
            r_size    <= w_size;
            r_sext    <= mem_sign_ext;
            r_off     <= addr[1:0];
            r_cnt     <= '0;
            bus_req   <= 1'b1;
            bus_we    <= mem_access_type[2];
            bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            bus_wstrb <= w_wstrb;
            bus_wdata <= w_wdata;
            r_state   <= REQ;
          end
        end
        REQ: if (bus_gnt) begin
          bus_req <= 1'b0;
          r_cnt   <= '0;
          done    <= bus_we;
          r_state <= bus_we ? IDLE : RESP;
        end else if (w_to) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
          r_state <= IDLE;
        end else r_cnt <= w_cnt_nxt;
        RESP: if (bus_rvalid) begin
          ld_data <= w_ld;
          done    <= 1'b1;
          r_state <= IDLE;
        end else if (w_to) begin
          bus_err <= 1'b1;
          r_state <= IDLE;
        end else r_cnt <= w_cnt_nxt;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of the load/store sequencer with a 4-cycle timeout.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  typ;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  int          n_chk = 0;
  int          n_err = 0;
  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_access_type(typ), .mem_sign_ext(sext), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .ld_data(ld_data), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_gnt(gnt), .bus_rvalid(rvalid), .bus_rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; req_valid = 1'b1; typ = 3'b011; sext = 1'b0; addr = 32'h1000;
    wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    tick();
    tick();
    chk("rst bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst misalign", {31'b0, misalign}, 32'd0);
    chk("rst bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst ld_data", ld_data, 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk("rst bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b0; rst_n = 1'b1;
    tick();
    chk("post-rst idle bus_req", {31'b0, bus_req}, 32'd0);
    chk("post-rst stall low", {31'b0, stall}, 32'd0);
    // LB signed, addr 0x1003
    req_valid = 1'b1; typ = 3'b001; sext = 1'b1; addr = 32'h1003;
    #1;
    chk("lb stall on request", {31'b0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("lb bus_req", {31'b0, bus_req}, 32'd1);
    chk("lb bus_addr", bus_addr, 32'h1000);
    chk("lb bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    chk("lb bus_we", {31'b0, bus_we}, 32'd0);
    chk("lb req_ready busy", {31'b0, req_ready}, 32'd0);
    chk("lb stall busy", {31'b0, stall}, 32'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("lb bus_req after gnt", {31'b0, bus_req}, 32'd0);
    chk("lb no early done", {31'b0, done}, 32'd0);
    rvalid = 1'b1; rdata = 32'h80FF_1234;
    tick();
    rvalid = 1'b0;
    chk("lb done", {31'b0, done}, 32'd1);
    chk("lb ld_data", ld_data, 32'hFFFF_FF80);
    tick();
    chk("lb done one cycle", {31'b0, done}, 32'd0);
    chk("lb back idle", {31'b0, req_ready}, 32'd1);
    // LHU, addr 0x2002
    req_valid = 1'b1; typ = 3'b010; sext = 1'b0; addr = 32'h2002;
    tick();
    req_valid = 1'b0;
    chk("lhu bus_addr", bus_addr, 32'h2000);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'hBEEF_0000;
    tick();
    rvalid = 1'b0;
    chk("lhu done", {31'b0, done}, 32'd1);
    chk("lhu ld_data", ld_data, 32'h0000_BEEF);
    // LW with sign_ext set and one idle cycle in RESP
    req_valid = 1'b1; typ = 3'b011; sext = 1'b1; addr = 32'h3000;
    tick();
    req_valid = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    chk("lw wait no done", {31'b0, done}, 32'd0);
    chk("lw ld_data held", ld_data, 32'h0000_BEEF);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    chk("lw done", {31'b0, done}, 32'd1);
    chk("lw ld_data", ld_data, 32'h1234_5678);
    tick();
    // SB addr 0x4002, grant withheld 3 cycles then given on the limit cycle
    req_valid = 1'b1; typ = 3'b101; sext = 1'b0; addr = 32'h4002; wdata = 32'hAABB_CCDD;
    tick();
    req_valid = 1'b0;
    chk("sb bus_we", {31'b0, bus_we}, 32'd1);
    chk("sb bus_wstrb", {28'b0, bus_wstrb}, 32'b0100);
    chk("sb bus_wdata", bus_wdata, 32'hDDDD_DDDD);
    chk("sb bus_addr", bus_addr, 32'h4000);
    tick();
    chk("sb hold1 bus_req", {31'b0, bus_req}, 32'd1);
    tick();
    chk("sb hold2 bus_req", {31'b0, bus_req}, 32'd1);
    tick();
    chk("sb hold3 bus_req", {31'b0, bus_req}, 32'd1);
    chk("sb hold3 bus_wdata", bus_wdata, 32'hDDDD_DDDD);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("sb done at limit", {31'b0, done}, 32'd1);
    chk("sb no bus_err at limit", {31'b0, bus_err}, 32'd0);
    chk("sb bus_req dropped", {31'b0, bus_req}, 32'd0);
    tick();
    chk("sb done one cycle", {31'b0, done}, 32'd0);
    // SH addr 0x4002
    req_valid = 1'b1; typ = 3'b110; addr = 32'h4002;
    tick();
    req_valid = 1'b0;
    chk("sh bus_wstrb", {28'b0, bus_wstrb}, 32'b1100);
    chk("sh bus_wdata", bus_wdata, 32'hCCDD_CCDD);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("sh done latency 2", {31'b0, done}, 32'd1);
    // SW addr 0x4000
    req_valid = 1'b1; typ = 3'b111; addr = 32'h4000;
    tick();
    req_valid = 1'b0;
    chk("sw bus_wstrb", {28'b0, bus_wstrb}, 32'b1111);
    chk("sw bus_wdata", bus_wdata, 32'hAABB_CCDD);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("sw done", {31'b0, done}, 32'd1);
    // Misaligned LW at 0x5001
    req_valid = 1'b1; typ = 3'b011; addr = 32'h5001;
    #1;
    chk("mis stall low", {31'b0, stall}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("mis pulse", {31'b0, misalign}, 32'd1);
    chk("mis no bus_req", {31'b0, bus_req}, 32'd0);
    chk("mis req_ready", {31'b0, req_ready}, 32'd1);
    chk("mis no done", {31'b0, done}, 32'd0);
    tick();
    chk("mis one cycle", {31'b0, misalign}, 32'd0);
    chk("mis still no bus_req", {31'b0, bus_req}, 32'd0);
    // Timeout in REQ: grant never comes
    req_valid = 1'b1; typ = 3'b011; addr = 32'h6000;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("to before limit bus_req", {31'b0, bus_req}, 32'd1);
    chk("to before limit bus_err", {31'b0, bus_err}, 32'd0);
    tick();
    chk("to bus_err", {31'b0, bus_err}, 32'd1);
    chk("to bus_req low", {31'b0, bus_req}, 32'd0);
    chk("to req_ready", {31'b0, req_ready}, 32'd1);
    chk("to no done", {31'b0, done}, 32'd0);
    chk("to ld_data unchanged", ld_data, 32'h1234_5678);
    tick();
    chk("to bus_err one cycle", {31'b0, bus_err}, 32'd0);
    // Reset while waiting in RESP, then a late rvalid
    req_valid = 1'b1; typ = 3'b011; addr = 32'h7000;
    tick();
    req_valid = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("resp-rst busy", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("resp-rst idle", {31'b0, req_ready}, 32'd1);
    chk("resp-rst bus_req", {31'b0, bus_req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    chk("late rvalid no done", {31'b0, done}, 32'd0);
    chk("late rvalid ld_data", ld_data, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
